// File: rtl/fetch_decode_skid_stage_pkg.sv
// Package fd_pipe_pkg: shared types and constants for the IF->ID skid stage.
//   fd_payload_t : default-width payload record {pc, pc_plus4, instr, pred}
//   fd_state_e   : skid FSM state encoding {EMPTY, BUSY, FULL}
//   RV_NOP       : addi x0,x0,0, the bubble encoding used by FD_BUBBLE_NOP_EN builds
package fd_pipe_pkg;

   localparam int unsigned FD_XLEN   = 32;
   localparam int unsigned FD_ILEN   = 32;
   localparam int unsigned FD_PRED_W = 1;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [FD_XLEN-1:0]   pc;
      logic [FD_XLEN-1:0]   pc_plus4;
      logic [FD_ILEN-1:0]   instr;
      logic [FD_PRED_W-1:0] pred;
   } fd_payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } fd_state_e;

endpackage

// File: rtl/fetch_decode_skid_stage_if.sv
// Valid/ready payload bus between pipeline stages.
//   valid    : producer presents a payload
//   ready    : consumer accepts
//   pc       : XLEN program counter
//   pc_plus4 : XLEN PC+4
//   instr    : ILEN instruction
//   pred     : PRED_W branch-predictor metadata
// Modports: master = producer side, slave = consumer side.
interface fetch_decode_skid_stage_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ILEN   = 32,
   parameter int unsigned PRED_W = 1
);

   logic              valid;
   logic              ready;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_plus4;
   logic [ILEN-1:0]   instr;
   logic [PRED_W-1:0] pred;

   modport master (
      output valid, pc, pc_plus4, instr, pred,
      input  ready
   );

   modport slave (
      input  valid, pc, pc_plus4, instr, pred,
      output ready
   );

endinterface

// File: rtl/fetch_decode_skid_stage.sv
// IF->ID pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// ready is registered, so the decode stall never reaches fetch combinationally.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-high (clears state and payload)
//   flush_i : synchronous kill of all held entries (redirect)
//   fetch   : slave side of the bus from fetch (valid/ready/pc/pc_plus4/instr/pred)
//   decode  : master side of the bus into decode
// Optional build macro FD_BUBBLE_NOP_EN: while valid is low, instr shows
// NOP_INSTR and pred shows 0 so decode may ignore valid.
module fetch_decode_skid_stage
   import fd_pipe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ILEN      = 32,
   parameter int unsigned PRED_W    = 1,
   parameter logic [31:0] NOP_INSTR = RV_NOP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   fetch_decode_skid_stage_if.slave   fetch,
   fetch_decode_skid_stage_if.master  decode
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_plus4;
      logic [ILEN-1:0]   instr;
      logic [PRED_W-1:0] pred;
   } payload_t;

   fd_state_e state_q;
   logic      valid_q;
   logic      ready_q;
   payload_t  main_q;
   payload_t  skid_q;
   payload_t  in_pl;
   logic      in_fire;
   logic      out_fire;

   assign in_pl    = '{pc: fetch.pc, pc_plus4: fetch.pc_plus4,
                       instr: fetch.instr, pred: fetch.pred};
   assign in_fire  = fetch.valid & ready_q;
   assign out_fire = valid_q & decode.ready;

   // valid_q/ready_q are loaded with the decode of the next state, so they
   // always equal (state!=EMPTY) and (state!=FULL) without output logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush_i) begin
         state_q <= EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_q  <= in_pl;
                  state_q <= BUSY;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_q <= in_pl;
               end else if (in_fire) begin
                  skid_q  <= in_pl;
                  state_q <= FULL;
                  ready_q <= 1'b0;
               end else if (out_fire) begin
                  state_q <= EMPTY;
                  valid_q <= 1'b0;
               end
            end
            FULL: begin
               // ready is low here, so no input can arrive alongside the drain
               if (out_fire) begin
                  main_q  <= skid_q;
                  state_q <= BUSY;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign fetch.ready     = ready_q;
   assign decode.valid    = valid_q;
   assign decode.pc       = main_q.pc;
   assign decode.pc_plus4 = main_q.pc_plus4;

`ifdef FD_BUBBLE_NOP_EN
   assign decode.instr = valid_q ? main_q.instr : ILEN'(NOP_INSTR);
   assign decode.pred  = valid_q ? main_q.pred  : '0;
`else
   assign decode.instr = main_q.instr;
   assign decode.pred  = main_q.pred;
`endif

endmodule

// File: tb/tb_fetch_decode_skid_stage.sv
// Directed table-driven bench for fetch_decode_skid_stage (PRED_W=2 build),
// plus hand-written sequences for a ready-pattern drain and predictor metadata.
module tb_fetch_decode_skid_stage;

   logic clk = 1'b0;
   logic rst;
   logic flush_i;

   always #5 clk = ~clk;

   fetch_decode_skid_stage_if #(.XLEN(32), .ILEN(32), .PRED_W(2)) fetch_bus ();
   fetch_decode_skid_stage_if #(.XLEN(32), .ILEN(32), .PRED_W(2)) decode_bus ();

   fetch_decode_skid_stage #(
      .XLEN   (32),
      .ILEN   (32),
      .PRED_W (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .fetch   (fetch_bus),
      .decode  (decode_bus)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic        vin;
      logic        rin;
      logic [31:0] pc;
      logic        ev;
      logic        er;
      logic        zero;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic v, input logic ri,
                      input logic [31:0] pc, input logic ev, input logic er,
                      input logic z, input logic [31:0] epc);
      vec_t t;
      t.rst = r; t.flush = f; t.vin = v; t.rin = ri; t.pc = pc;
      t.ev = ev; t.er = er; t.zero = z; t.epc = epc;
      vecs.push_back(t);
   endtask

   initial begin
      logic [31:0] e_instr;
      logic [31:0] e_pred;
      logic [7:0]  pat;
      int          sent;
      int          recv;
      logic        in_fire;
      logic        out_fire;

      //   rst flush vin rin pc       ev er zero epc
      // reset, two cycles
      add(1, 0, 0, 1, 32'h00, 0, 1, 1, 32'h00);
      add(1, 0, 0, 1, 32'h00, 0, 1, 1, 32'h00);
      // streaming at full rate
      add(0, 0, 1, 1, 32'h00, 1, 1, 0, 32'h00);
      add(0, 0, 1, 1, 32'h04, 1, 1, 0, 32'h04);
      add(0, 0, 1, 1, 32'h08, 1, 1, 0, 32'h08);
      add(0, 0, 0, 1, 32'h0C, 0, 1, 0, 32'h00);
      // stall: 0x10, 0x14 accepted, 0x18 held upstream, then drain in order
      add(0, 0, 1, 0, 32'h10, 1, 1, 0, 32'h10);
      add(0, 0, 1, 0, 32'h14, 1, 0, 0, 32'h10);
      add(0, 0, 1, 0, 32'h18, 1, 0, 0, 32'h10);
      add(0, 0, 1, 1, 32'h18, 1, 1, 0, 32'h14);
      add(0, 0, 1, 1, 32'h18, 1, 1, 0, 32'h18);
      add(0, 0, 0, 1, 32'h1C, 0, 1, 0, 32'h00);
      // flush while FULL with a same-cycle input of 0x20
      add(0, 0, 1, 0, 32'h30, 1, 1, 0, 32'h30);
      add(0, 0, 1, 0, 32'h34, 1, 0, 0, 32'h30);
      add(0, 1, 1, 0, 32'h20, 0, 1, 0, 32'h00);
      add(0, 0, 0, 1, 32'h20, 0, 1, 0, 32'h00);
      add(0, 0, 1, 1, 32'h40, 1, 1, 0, 32'h40);
      add(0, 0, 0, 1, 32'h44, 0, 1, 0, 32'h00);
      // reset while FULL
      add(0, 0, 1, 0, 32'h50, 1, 1, 0, 32'h50);
      add(0, 0, 1, 0, 32'h54, 1, 0, 0, 32'h50);
      add(1, 0, 1, 0, 32'h58, 0, 1, 1, 32'h00);
      // reset and flush together while FULL
      add(0, 0, 1, 0, 32'h60, 1, 1, 0, 32'h60);
      add(0, 0, 1, 0, 32'h64, 1, 0, 0, 32'h60);
      add(1, 1, 1, 0, 32'h68, 0, 1, 1, 32'h00);
      add(0, 0, 0, 1, 32'h6C, 0, 1, 1, 32'h00);

      flush_i = 1'b0;
      rst     = 1'b1;
      fetch_bus.valid    = 1'b0;
      fetch_bus.pc       = '0;
      fetch_bus.pc_plus4 = '0;
      fetch_bus.instr    = '0;
      fetch_bus.pred     = '0;
      decode_bus.ready   = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         rst                = vecs[i].rst;
         flush_i            = vecs[i].flush;
         fetch_bus.valid    = vecs[i].vin;
         fetch_bus.pc       = vecs[i].pc;
         fetch_bus.pc_plus4 = vecs[i].pc + 32'd4;
         fetch_bus.instr    = 32'h1000_0000 | vecs[i].pc;
         fetch_bus.pred     = vecs[i].pc[3:2];
         decode_bus.ready   = vecs[i].rin;
         @(posedge clk);
         #1;
         check($sformatf("v%0d valid_o", i), {31'b0, decode_bus.valid}, {31'b0, vecs[i].ev});
         check($sformatf("v%0d ready_o", i), {31'b0, fetch_bus.ready}, {31'b0, vecs[i].er});
         if (vecs[i].ev) begin
            e_instr = 32'h1000_0000 | vecs[i].epc;
            e_pred  = {30'b0, vecs[i].epc[3:2]};
            check($sformatf("v%0d pc_o", i), decode_bus.pc, vecs[i].epc);
            check($sformatf("v%0d pc_plus4_o", i), decode_bus.pc_plus4, vecs[i].epc + 32'd4);
            check($sformatf("v%0d instr_o", i), decode_bus.instr, e_instr);
            check($sformatf("v%0d pred_o", i), {30'b0, decode_bus.pred}, e_pred);
         end else begin
`ifdef FD_BUBBLE_NOP_EN
            check($sformatf("v%0d bubble instr_o", i), decode_bus.instr, 32'h0000_0013);
            check($sformatf("v%0d bubble pred_o", i), {30'b0, decode_bus.pred}, 32'h0);
`endif
            if (vecs[i].zero) begin
               check($sformatf("v%0d rst pc_o", i), decode_bus.pc, 32'h0);
               check($sformatf("v%0d rst pc_plus4_o", i), decode_bus.pc_plus4, 32'h0);
`ifndef FD_BUBBLE_NOP_EN
               check($sformatf("v%0d rst instr_o", i), decode_bus.instr, 32'h0);
               check($sformatf("v%0d rst pred_o", i), {30'b0, decode_bus.pred}, 32'h0);
`endif
            end
         end
      end

      // Drain under an irregular ready pattern: order and count must hold.
      rst     = 1'b0;
      flush_i = 1'b0;
      pat     = 8'b1011_0010;
      sent    = 0;
      recv    = 0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         fetch_bus.valid    = (sent < 8);
         fetch_bus.pc       = 32'h200 + 32'(4 * sent);
         fetch_bus.pc_plus4 = 32'h204 + 32'(4 * sent);
         fetch_bus.instr    = 32'h1000_0200 + 32'(4 * sent);
         fetch_bus.pred     = 2'(sent);
         decode_bus.ready   = pat[cyc % 8];
         #1;
         in_fire  = fetch_bus.valid & fetch_bus.ready;
         out_fire = decode_bus.valid & decode_bus.ready;
         if (out_fire) begin
            check($sformatf("drain pc_o #%0d", recv), decode_bus.pc, 32'h200 + 32'(4 * recv));
            check($sformatf("drain instr_o #%0d", recv), decode_bus.instr,
                  32'h1000_0200 + 32'(4 * recv));
            recv++;
         end
         if (in_fire) sent++;
         @(posedge clk);
         #1;
      end
      check("drain count", 32'(recv), 32'd8);

      // Two-bit predictor metadata carried with its instruction.
      decode_bus.ready   = 1'b1;
      fetch_bus.valid    = 1'b1;
      fetch_bus.pc       = 32'h100;
      fetch_bus.pc_plus4 = 32'h104;
      fetch_bus.instr    = 32'h00A0_0093;
      fetch_bus.pred     = 2'b10;
      @(posedge clk);
      #1;
      check("pred valid_o", {31'b0, decode_bus.valid}, 32'h1);
      check("pred instr_o", decode_bus.instr, 32'h00A0_0093);
      check("pred pred_o", {30'b0, decode_bus.pred}, 32'h2);
      check("pred pc_o", decode_bus.pc, 32'h100);
      fetch_bus.valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle valid_o", {31'b0, decode_bus.valid}, 32'h0);
`ifdef FD_BUBBLE_NOP_EN
      check("idle bubble instr_o", decode_bus.instr, 32'h0000_0013);
      check("idle bubble pred_o", {30'b0, decode_bus.pred}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
